// File: rtl/freq_display_scan.sv
// -----------------------------------------------------------------------------
// freq_display_scan
// Multiplexes six BCD frequency digits plus a magnitude code onto a 6-position
// common-anode 7-segment display.
//
// The digits and unit are copied into a shadow register once per frame. The
// copy happens at the 5->0 position wrap, and also in the first slot after
// reset. Because of this, the display never mixes two measurements within one
// frame. Each slot starts with a short all-off gap so that the previous digit
// does not ghost onto the next position.
//
// Ports
//   ADC_clk                  in   sole clock
//   rst                      in   synchronous, active-low reset
//   freq_dig_5..freq_dig_0   in   BCD digits, 5 = most significant
//   unit                     in   magnitude code (0..2 mHz, 3..5 Hz, 6/7 overflow)
//   hold                     in   1 = freeze the shadow copy
//   seg_n                    out  active-low segments [0]=a..[6]=g, [7]=dp
//   dig_sel_n                out  active-low digit enables, bit p = position p
//   frame_tick               out  one-cycle pulse after each shadow load
// -----------------------------------------------------------------------------
module freq_display_scan #(
    parameter int CLK_HZ    = 40_000_000,
    parameter int FRAME_HZ  = 500,
    parameter int BLANK_CYC = 64
) (
    input  logic       ADC_clk,
    input  logic       rst,
    input  logic [3:0] freq_dig_5,
    input  logic [3:0] freq_dig_4,
    input  logic [3:0] freq_dig_3,
    input  logic [3:0] freq_dig_2,
    input  logic [3:0] freq_dig_1,
    input  logic [3:0] freq_dig_0,
    input  logic [2:0] unit,
    input  logic       hold,
    output logic [7:0] seg_n,
    output logic [5:0] dig_sel_n,
    output logic       frame_tick
);

    localparam int SLOT = CLK_HZ / (6 * FRAME_HZ);
    localparam int CW   = (SLOT > 1) ? $clog2(SLOT) : 1;

    logic [CW-1:0] cnt_reg;
    logic [2:0]    idx_reg;
    logic          first_reg;      // set by reset so that the first slot loads
    logic [3:0]    shadow_reg [6];
    logic [2:0]    unit_reg;
    logic [7:0]    seg_n_reg;
    logic [5:0]    dig_sel_n_reg;
    logic          frame_tick_reg;

    logic [7:0]    seg_n_next;
    logic [5:0]    dig_sel_n_next;

    logic [3:0]    dig_in [6];
    logic [5:0]    digit_zero;
    logic [5:0]    zero_run;       // bit p: shadow digits 5..p are all zero
    logic          slot_end;
    logic          load;

    assign dig_in[0] = freq_dig_0;
    assign dig_in[1] = freq_dig_1;
    assign dig_in[2] = freq_dig_2;
    assign dig_in[3] = freq_dig_3;
    assign dig_in[4] = freq_dig_4;
    assign dig_in[5] = freq_dig_5;

    assign slot_end = (cnt_reg == CW'(SLOT - 1));
    assign load     = ((slot_end && (idx_reg == 3'd5)) || first_reg) && !hold;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_zero
            assign digit_zero[gi] = (shadow_reg[gi] == 4'd0);
            assign zero_run[gi]   = &digit_zero[5:gi];
        end
    endgenerate

    // Active-high gfedcba. Non-BCD codes render as 'E'.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h79;
        endcase
    endfunction

    always_comb begin
        logic       milli;
        logic       overflow;
        logic [2:0] blank_floor;
        logic [7:0] pat;

        seg_n_next     = 8'hFF;
        dig_sel_n_next = 6'h3F;
        milli          = (unit_reg <= 3'd2);
        overflow       = (unit_reg >= 3'd6);
        blank_floor    = milli ? 3'd3 : 3'd0;
        pat            = 8'h00;

        if (cnt_reg >= CW'(BLANK_CYC)) begin
            dig_sel_n_next = ~(6'd1 << idx_reg);
            if (overflow) begin
                pat = 8'h40;
            end else if ((idx_reg > blank_floor) && zero_run[idx_reg]) begin
                pat = 8'h00;
            end else begin
                pat = {milli && (idx_reg == 3'd3), seg7(shadow_reg[idx_reg])};
            end
            seg_n_next = ~pat;
        end
    end

    always_ff @(posedge ADC_clk) begin
        if (!rst) begin
            cnt_reg        <= '0;
            idx_reg        <= 3'd0;
            first_reg      <= 1'b1;
            unit_reg       <= 3'd0;
            seg_n_reg      <= 8'hFF;
            dig_sel_n_reg  <= 6'h3F;
            frame_tick_reg <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt_reg <= '0;
                idx_reg <= (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
            first_reg      <= 1'b0;
            if (load) begin
                unit_reg <= unit;
            end
            seg_n_reg      <= seg_n_next;
            dig_sel_n_reg  <= dig_sel_n_next;
            frame_tick_reg <= load;
        end
    end

    generate
        for (gi = 0; gi < 6; gi++) begin : g_shadow
            always_ff @(posedge ADC_clk) begin
                if (!rst) begin
                    shadow_reg[gi] <= 4'd0;
                end else if (load) begin
                    shadow_reg[gi] <= dig_in[gi];
                end
            end
        end
    endgenerate

    assign seg_n      = seg_n_reg;
    assign dig_sel_n  = dig_sel_n_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_freq_display_scan.sv
// -----------------------------------------------------------------------------
// tb_freq_display_scan
// Directed bench. It uses SLOT=10 and BLANK_CYC=2, so one frame is 60 cycles.
// Every expected segment code below was worked out by hand from the digit table.
// -----------------------------------------------------------------------------
module tb_freq_display_scan;

    logic       clk;
    logic       rst;
    logic [3:0] d5, d4, d3, d2, d1, d0;
    logic [2:0] unit;
    logic       hold;
    logic [7:0] seg_n;
    logic [5:0] dig_sel_n;
    logic       frame_tick;

    int n_checks;
    int n_errors;
    logic [7:0] exp_seg [6];

    freq_display_scan #(
        .CLK_HZ   (120),
        .FRAME_HZ (2),
        .BLANK_CYC(2)
    ) dut (
        .ADC_clk   (clk),
        .rst       (rst),
        .freq_dig_5(d5),
        .freq_dig_4(d4),
        .freq_dig_3(d3),
        .freq_dig_2(d2),
        .freq_dig_1(d1),
        .freq_dig_0(d0),
        .unit      (unit),
        .hold      (hold),
        .seg_n     (seg_n),
        .dig_sel_n (dig_sel_n),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end else begin
            $display("ok   %s: %02h", tag, got);
        end
    endtask

    task automatic set_in(input logic [3:0] a5, a4, a3, a2, a1, a0, input logic [2:0] u);
        d5 = a5; d4 = a4; d3 = a3; d2 = a2; d1 = a1; d0 = a0; unit = u;
    endtask

    task automatic set_exp(input logic [7:0] e5, e4, e3, e2, e1, e0);
        exp_seg[5] = e5; exp_seg[4] = e4; exp_seg[3] = e3;
        exp_seg[2] = e2; exp_seg[1] = e1; exp_seg[0] = e0;
    endtask

    // Returns at the negedge of the cycle in which frame_tick is high.
    task automatic wait_tick();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) found = 1'b1;
        end
        if (!found) check("tick_timeout", 8'd0, 8'd1);
    endtask

    // Call this right after a tick cycle. In cycle k the outputs reflect
    // position (k-1)/10 at count (k-1)%10. Counts 0 and 1 are off, and
    // counts 2..9 are on. Cycle 60 is the next tick cycle.
    task automatic check_frame(input logic exp_tick);
        int p, c;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            p = (k - 1) / 10;
            c = (k - 1) % 10;
            if (c == 1) begin
                check($sformatf("gap_seg p%0d", p), seg_n, 8'hFF);
                check($sformatf("gap_dig p%0d", p), {2'b00, dig_sel_n}, 8'h3F);
            end else if (c == 2 || c == 9) begin
                check($sformatf("seg p%0d c%0d", p, c), seg_n, exp_seg[p]);
                check($sformatf("dig p%0d c%0d", p, c), {2'b00, dig_sel_n},
                      {2'b00, ~(6'd1 << p)});
            end
            if (c == 5) check($sformatf("tick_mid p%0d", p), {7'd0, frame_tick}, 8'd0);
            if (k == 60) check("tick_end", {7'd0, frame_tick}, {7'd0, exp_tick});
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst  = 1'b0;
        hold = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 3'd0);

        // 1: reset, then a frame of zeros in mHz mode, shown as "0.000"
        repeat (5) @(negedge clk);
        check("rst_seg", seg_n, 8'hFF);
        check("rst_dig", {2'b00, dig_sel_n}, 8'h3F);
        check("rst_tick", {7'd0, frame_tick}, 8'd0);
        rst = 1'b1;
        @(negedge clk);
        check("first_load_tick", {7'd0, frame_tick}, 8'd1);
        wait_tick();
        set_exp(8'hFF, 8'hFF, 8'h40, 8'hC0, 8'hC0, 8'hC0);
        check_frame(1'b1);

        // 2: "1.234", mHz mode
        set_in(0, 0, 1, 2, 3, 4, 3'd0);
        wait_tick();
        set_exp(8'hFF, 8'hFF, 8'h79, 8'hA4, 8'hB0, 8'h99);
        check_frame(1'b1);

        // 3: "12345", Hz mode, blank floor 0
        set_in(0, 1, 2, 3, 4, 5, 3'd3);
        wait_tick();
        set_exp(8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92);
        check_frame(1'b1);

        // 4: overflow shows dashes everywhere
        set_in(1, 2, 3, 4, 5, 6, 3'd6);
        wait_tick();
        set_exp(8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF);
        check_frame(1'b1);

        // 5: hold freezes the display. Releasing it loads at the next wrap.
        hold = 1'b1;
        set_in(9, 8, 7, 6, 5, 4, 3'd4);
        check_frame(1'b0);
        hold = 1'b0;
        check_frame(1'b1);
        set_exp(8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99);
        check_frame(1'b1);

        // 6: non-BCD digit shows 'E'. Reset mid-slot restarts the scan.
        set_in(0, 0, 0, 0, 1, 4'hC, 3'd3);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_seg", seg_n, 8'hFF);
        check("midrst_dig", {2'b00, dig_sel_n}, 8'h3F);
        check("midrst_tick", {7'd0, frame_tick}, 8'd0);
        rst = 1'b1;
        for (int j = 1; j <= 13; j++) begin
            @(negedge clk);
            if (j == 1)  check("restart_tick", {7'd0, frame_tick}, 8'd1);
            if (j == 2)  check("restart_gap_dig", {2'b00, dig_sel_n}, 8'h3F);
            if (j == 3) begin
                check("restart_p0_dig", {2'b00, dig_sel_n}, 8'h3E);
                check("restart_p0_seg", seg_n, 8'h86);
            end
            if (j == 12) check("restart_gap1_seg", seg_n, 8'hFF);
            if (j == 13) begin
                check("restart_p1_dig", {2'b00, dig_sel_n}, 8'h3D);
                check("restart_p1_seg", seg_n, 8'hF9);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
